// File: rtl/guess_grader_if.sv
// Grader-side bundle: master code and guess in, scores and game status out.
interface guess_grader_if;
  logic [2:0] master0, master1, master2, master3;
  logic       masterLoaded;
  logic       gamePlaying;
  logic [2:0] guess0, guess1, guess2, guess3;
  logic       gradeIt;
  logic       ready;
  logic [2:0] znarly;
  logic [2:0] zood;
  logic       gradeDone;
  logic [3:0] roundCount;
  logic       gameWon;
  logic       gameOver;

  modport master (
    output master0, master1, master2, master3, masterLoaded, gamePlaying,
           guess0, guess1, guess2, guess3, gradeIt,
    input  ready, znarly, zood, gradeDone, roundCount, gameWon, gameOver
  );

  modport slave (
    input  master0, master1, master2, master3, masterLoaded, gamePlaying,
           guess0, guess1, guess2, guess3, gradeIt,
    output ready, znarly, zood, gradeDone, roundCount, gameWon, gameOver
  );
endinterface

// File: rtl/guess_grader.sv
// Multi-cycle guess grader: one exact-match pass, then one partial-match step per
// guess slot; tracks rounds, win and game-over.
module guess_grader #(
  parameter int unsigned MAX_ROUNDS = 8
) (
  input logic          CLOCK_50,
  input logic          reset,
  guess_grader_if.slave gg
);
  localparam logic [3:0] ROUND_LIMIT = 4'(MAX_ROUNDS);

  typedef enum logic [1:0] {IDLE, EXACT, PARTIAL, DONE} state_t;
  state_t state, state_nx;

  logic [2:0] g [4];
  logic [2:0] m [4];
  logic [3:0] gused, mused;
  logic [2:0] exact_cnt, part_cnt;
  logic [1:0] idx;

  logic [2:0] znarly_q, zood_q;
  logic [3:0] round_q;
  logic       won_q;

  logic       over, guess_full, accept, hit, grade_done;
  logic [1:0] hit_j;
  logic [3:0] exact_vec;
  logic [2:0] exact_sum;

  always_comb begin
    over       = won_q | (round_q == ROUND_LIMIT);
    guess_full = (gg.guess0 != '0) & (gg.guess1 != '0) &
                 (gg.guess2 != '0) & (gg.guess3 != '0);
    accept     = gg.gradeIt & gg.gamePlaying & gg.masterLoaded & ~over & guess_full;
  end

  always_comb begin
    exact_vec = '0;
    exact_sum = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      exact_vec[k] = (g[k] == m[k]);
      exact_sum    = exact_sum + 3'(exact_vec[k]);
    end
  end

  // Lowest unused master slot holding the shape of guess slot idx.
  always_comb begin
    hit   = 1'b0;
    hit_j = '0;
    for (int unsigned j = 0; j < 4; j++) begin
      if (!hit && !mused[j] && (m[j] == g[idx])) begin
        hit   = 1'b1;
        hit_j = 2'(j);
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = EXACT;
      EXACT:   state_nx = PARTIAL;
      PARTIAL: if (idx == 2'd3) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (state != IDLE && !gg.gamePlaying) state_nx = IDLE;
  end

  // An abort during DONE suppresses the pulse and the output update together.
  assign grade_done = (state == DONE) && gg.gamePlaying;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int unsigned k = 0; k < 4; k++) begin
        g[k] <= '0;
        m[k] <= '0;
      end
      gused     <= '0;
      mused     <= '0;
      exact_cnt <= '0;
      part_cnt  <= '0;
      idx       <= '0;
      znarly_q  <= '0;
      zood_q    <= '0;
      round_q   <= '0;
      won_q     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            g[0] <= gg.guess0;  g[1] <= gg.guess1;
            g[2] <= gg.guess2;  g[3] <= gg.guess3;
            m[0] <= gg.master0; m[1] <= gg.master1;
            m[2] <= gg.master2; m[3] <= gg.master3;
            gused <= '0;
            mused <= '0;
          end
        end
        EXACT: begin
          gused     <= exact_vec;
          mused     <= exact_vec;
          exact_cnt <= exact_sum;
          part_cnt  <= '0;
          idx       <= '0;
        end
        PARTIAL: begin
          if (!gused[idx] && hit) begin
            mused[hit_j] <= 1'b1;
            part_cnt     <= part_cnt + 3'd1;
          end
          idx <= idx + 2'd1;
        end
        DONE: begin
          if (gg.gamePlaying) begin
            znarly_q <= exact_cnt;
            zood_q   <= part_cnt;
            if (round_q != ROUND_LIMIT) round_q <= round_q + 4'd1;
            if (exact_cnt == 3'd4) won_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign gg.ready      = (state == IDLE) && !over;
  assign gg.znarly     = znarly_q;
  assign gg.zood       = zood_q;
  assign gg.gradeDone  = grade_done;
  assign gg.roundCount = round_q;
  assign gg.gameWon    = won_q;
  assign gg.gameOver   = over;
endmodule

// File: tb/tb_guess_grader.sv
// Bench for guess_grader: directed scenarios plus randomized games scored by a
// shape-count reference model.
module tb_guess_grader;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;

  // reference-model game state
  int   m_rounds;
  bit   m_won;
  int   m_zn, m_zo;

  guess_grader_if gif ();

  guess_grader #(.MAX_ROUNDS(8)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .gg       (gif)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [11:0] pack4(input int a, input int b, input int c, input int d);
    return {3'(d), 3'(c), 3'(b), 3'(a)};
  endfunction

  // Score = per-shape overlap of the two multisets, split into same-slot and the rest.
  function automatic void ref_grade(input logic [11:0] mv, input logic [11:0] gv,
                                    output int ex, output int pa);
    int tot = 0;
    ex = 0;
    for (int k = 0; k < 4; k++)
      if (mv[3*k +: 3] == gv[3*k +: 3]) ex++;
    for (int s = 1; s <= 7; s++) begin
      int cm = 0, cg = 0;
      for (int k = 0; k < 4; k++) begin
        if (mv[3*k +: 3] == 3'(s)) cm++;
        if (gv[3*k +: 3] == 3'(s)) cg++;
      end
      tot += (cm < cg) ? cm : cg;
    end
    pa = tot - ex;
  endfunction

  task automatic set_master(input logic [11:0] mv);
    gif.master0 = mv[2:0]; gif.master1 = mv[5:3];
    gif.master2 = mv[8:6]; gif.master3 = mv[11:9];
  endtask

  task automatic set_guess(input logic [11:0] gv);
    gif.guess0 = gv[2:0]; gif.guess1 = gv[5:3];
    gif.guess2 = gv[8:6]; gif.guess3 = gv[11:9];
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_rounds = 0; m_won = 0; m_zn = 0; m_zo = 0;
  endtask

  // Presents one request for a single edge, then watches 10 cycles. done_cyc is the
  // first cycle after the accept edge with gradeDone high (0 = never); rdy_bad flags
  // ready high during cycles 1..6. scramble perturbs the master inputs mid-grade.
  task automatic run_grade(input logic [11:0] gv, input bit scramble,
                           output int done_cyc, output bit rdy_bad);
    logic [11:0] saved;
    saved = {gif.master3, gif.master2, gif.master1, gif.master0};
    @(negedge clk);
    set_guess(gv);
    gif.gradeIt = 1'b1;
    @(posedge clk);
    #1;
    gif.gradeIt = 1'b0;
    if (scramble)
      set_master(pack4($urandom_range(1,7), $urandom_range(1,7),
                       $urandom_range(1,7), $urandom_range(1,7)));
    done_cyc = 0;
    rdy_bad  = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (gif.gradeDone && done_cyc == 0) done_cyc = c;
      if (c <= 6 && gif.ready) rdy_bad = 1'b1;
    end
    set_master(saved);
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({gif.znarly, gif.zood, gif.gradeDone, gif.roundCount, gif.gameWon, gif.gameOver, gif.ready}
        !== {3'd0, 3'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL reset_state got zn=%0d zo=%0d gd=%b rc=%0d won=%b over=%b rdy=%b want 0/0/0/0/0/0/1",
               gif.znarly, gif.zood, gif.gradeDone, gif.roundCount, gif.gameWon, gif.gameOver, gif.ready);
    end
  endtask

  task automatic test_exact_win();
    int dc; bit rb;
    do_reset();
    set_master(pack4(1,2,3,4));
    run_grade(pack4(1,2,3,4), 1'b0, dc, rb);
    tests++;
    if (dc !== 6) begin fails++; $display("FAIL win_latency got %0d want 6", dc); end
    tests++;
    if (rb !== 1'b0) begin fails++; $display("FAIL win_ready_busy got ready high want low"); end
    tests++;
    if ({gif.znarly, gif.zood, gif.roundCount, gif.gameWon, gif.gameOver, gif.ready}
        !== {3'd4, 3'd0, 4'd1, 1'b1, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL win_result got zn=%0d zo=%0d rc=%0d won=%b over=%b rdy=%b want 4/0/1/1/1/0",
               gif.znarly, gif.zood, gif.roundCount, gif.gameWon, gif.gameOver, gif.ready);
    end
    run_grade(pack4(4,3,2,1), 1'b0, dc, rb);
    tests++;
    if (dc !== 0 || gif.roundCount !== 4'd1 || gif.znarly !== 3'd4) begin
      fails++;
      $display("FAIL win_ignore got done=%0d rc=%0d zn=%0d want 0/1/4", dc, gif.roundCount, gif.znarly);
    end
  endtask

  task automatic test_patterns();
    logic [11:0] mt [3];
    logic [11:0] gt [3];
    int ez [3];
    int eo [3];
    int dc; bit rb;
    mt[0] = pack4(1,2,3,4); gt[0] = pack4(4,3,2,1); ez[0] = 0; eo[0] = 4;
    mt[1] = pack4(1,1,2,2); gt[1] = pack4(1,2,1,1); ez[1] = 1; eo[1] = 2;
    mt[2] = pack4(5,5,5,1); gt[2] = pack4(5,1,1,1); ez[2] = 2; eo[2] = 0;
    do_reset();
    for (int p = 0; p < 3; p++) begin
      set_master(mt[p]);
      run_grade(gt[p], 1'b1, dc, rb);
      tests++;
      if (dc !== 6 || gif.znarly !== 3'(ez[p]) || gif.zood !== 3'(eo[p]) ||
          gif.roundCount !== 4'(p + 1) || gif.gameWon !== 1'b0) begin
        fails++;
        $display("FAIL pattern%0d got done=%0d zn=%0d zo=%0d rc=%0d won=%b want 6/%0d/%0d/%0d/0",
                 p, dc, gif.znarly, gif.zood, gif.roundCount, gif.gameWon, ez[p], eo[p], p + 1);
      end
    end
  endtask

  task automatic test_invalid();
    int dc; bit rb;
    do_reset();
    set_master(pack4(1,2,3,4));
    for (int v = 0; v < 3; v++) begin
      gif.masterLoaded = (v != 1);
      gif.gamePlaying  = (v != 2);
      run_grade((v == 0) ? pack4(3,0,2,1) : pack4(1,2,3,4), 1'b0, dc, rb);
      tests++;
      if (dc !== 0 || gif.roundCount !== 4'd0 || gif.znarly !== 3'd0) begin
        fails++;
        $display("FAIL invalid%0d got done=%0d rc=%0d zn=%0d want 0/0/0", v, dc, gif.roundCount, gif.znarly);
      end
    end
    gif.masterLoaded = 1'b1;
    gif.gamePlaying  = 1'b1;
  endtask

  task automatic test_rounds();
    int dc; bit rb; int bad;
    do_reset();
    set_master(pack4(1,2,3,4));
    bad = 0;
    for (int r = 0; r < 8; r++) begin
      run_grade(pack4(7,7,7,7), 1'b0, dc, rb);
      if (dc != 6 || gif.znarly !== 3'd0 || gif.zood !== 3'd0) bad++;
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL rounds_grades got %0d bad grades want 0", bad); end
    tests++;
    if ({gif.roundCount, gif.gameOver, gif.ready, gif.gameWon} !== {4'd8, 1'b1, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL rounds_over got rc=%0d over=%b rdy=%b won=%b want 8/1/0/0",
               gif.roundCount, gif.gameOver, gif.ready, gif.gameWon);
    end
    run_grade(pack4(1,2,3,4), 1'b0, dc, rb);
    tests++;
    if (dc !== 0 || gif.roundCount !== 4'd8 || gif.gameWon !== 1'b0) begin
      fails++;
      $display("FAIL rounds_ninth got done=%0d rc=%0d won=%b want 0/8/0", dc, gif.roundCount, gif.gameWon);
    end
  endtask

  task automatic test_reset_mid();
    int dc; bit rb;
    do_reset();
    set_master(pack4(1,2,3,4));
    run_grade(pack4(4,3,2,1), 1'b0, dc, rb);
    @(negedge clk);
    set_guess(pack4(1,2,3,4));
    gif.gradeIt = 1'b1;
    @(posedge clk);
    #1;
    gif.gradeIt = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests++;
    if ({gif.znarly, gif.zood, gif.gradeDone, gif.roundCount, gif.gameWon, gif.gameOver, gif.ready}
        !== {3'd0, 3'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL midreset_state got zn=%0d zo=%0d gd=%b rc=%0d won=%b rdy=%b want 0/0/0/0/0/1",
               gif.znarly, gif.zood, gif.gradeDone, gif.roundCount, gif.gameWon, gif.ready);
    end
    dc = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (gif.gradeDone) dc = 1;
    end
    tests++;
    if (dc !== 0) begin fails++; $display("FAIL midreset_discard got gradeDone=1 want 0"); end
    run_grade(pack4(1,2,3,4), 1'b0, dc, rb);
    tests++;
    if (dc !== 6 || gif.roundCount !== 4'd1 || gif.znarly !== 3'd4) begin
      fails++;
      $display("FAIL midreset_regrade got done=%0d rc=%0d zn=%0d want 6/1/4", dc, gif.roundCount, gif.znarly);
    end
    m_rounds = 0;
  endtask

  task automatic test_abort();
    int dc; bit rb; int seen;
    do_reset();
    set_master(pack4(1,2,3,4));
    run_grade(pack4(4,3,2,1), 1'b0, dc, rb);
    @(negedge clk);
    set_guess(pack4(1,2,3,4));
    gif.gradeIt = 1'b1;
    @(posedge clk);
    #1;
    gif.gradeIt = 1'b0;
    @(negedge clk);
    gif.gamePlaying = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (gif.gradeDone) seen++;
    end
    gif.gamePlaying = 1'b1;
    @(negedge clk);
    tests++;
    if (seen != 0 || {gif.znarly, gif.zood, gif.roundCount, gif.gameWon, gif.ready}
                     !== {3'd0, 3'd4, 4'd1, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL abort got pulses=%0d zn=%0d zo=%0d rc=%0d won=%b rdy=%b want 0/0/4/1/0/1",
               seen, gif.znarly, gif.zood, gif.roundCount, gif.gameWon, gif.ready);
    end
  endtask

  task automatic test_back_to_back();
    int first, second;
    do_reset();
    set_master(pack4(1,2,3,4));
    @(negedge clk);
    set_guess(pack4(4,3,2,1));
    gif.gradeIt = 1'b1;
    @(posedge clk);
    first = 0; second = 0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 8) gif.gradeIt = 1'b0;
      if (gif.gradeDone) begin
        if (first == 0) first = c;
        else if (second == 0) second = c;
      end
    end
    tests++;
    if (first !== 6 || second !== 13 || gif.roundCount !== 4'd2) begin
      fails++;
      $display("FAIL back_to_back got pulses@%0d,%0d rc=%0d want 6,13 rc=2", first, second, gif.roundCount);
    end
  endtask

  task automatic test_random();
    logic [11:0] mv, gv;
    int dc, ex, pa, narrow;
    bit rb, acc, gp, ml;
    do_reset();
    narrow = 0;
    mv = pack4($urandom_range(1,7), $urandom_range(1,7), $urandom_range(1,7), $urandom_range(1,7));
    for (int it = 0; it < 60; it++) begin
      if (m_won || m_rounds == 8) begin
        do_reset();
        narrow = $urandom_range(0,1);
        mv = narrow ? pack4($urandom_range(1,3), $urandom_range(1,3), $urandom_range(1,3), $urandom_range(1,3))
                    : pack4($urandom_range(1,7), $urandom_range(1,7), $urandom_range(1,7), $urandom_range(1,7));
      end
      set_master(mv);
      for (int k = 0; k < 4; k++)
        gv[3*k +: 3] = 3'(narrow ? $urandom_range(1,3) : $urandom_range(1,7));
      if ($urandom_range(0,7) == 0) gv[3*$urandom_range(0,3) +: 3] = 3'd0;
      gp = ($urandom_range(0,9) != 0);
      ml = ($urandom_range(0,9) != 0);
      gif.gamePlaying  = gp;
      gif.masterLoaded = ml;
      acc = gp && ml && !m_won && (m_rounds != 8) &&
            gv[2:0] != 0 && gv[5:3] != 0 && gv[8:6] != 0 && gv[11:9] != 0;
      run_grade(gv, 1'b1, dc, rb);
      gif.gamePlaying  = 1'b1;
      gif.masterLoaded = 1'b1;
      if (acc) begin
        ref_grade(mv, gv, ex, pa);
        m_zn = ex; m_zo = pa;
        m_rounds++;
        if (ex == 4) m_won = 1;
      end
      tests++;
      if (dc !== (acc ? 6 : 0) || (acc && rb)) begin
        fails++;
        $display("FAIL rand%0d_timing got done=%0d rdybusy=%b want done=%0d", it, dc, rb, acc ? 6 : 0);
      end
      tests++;
      if (gif.znarly !== 3'(m_zn) || gif.zood !== 3'(m_zo) || gif.roundCount !== 4'(m_rounds) ||
          gif.gameWon !== m_won || gif.gameOver !== (m_won || m_rounds == 8)) begin
        fails++;
        $display("FAIL rand%0d_score m=%h g=%h got zn=%0d zo=%0d rc=%0d won=%b over=%b want %0d/%0d/%0d/%0d/%0d",
                 it, mv, gv, gif.znarly, gif.zood, gif.roundCount, gif.gameWon, gif.gameOver,
                 m_zn, m_zo, m_rounds, m_won, (m_won || m_rounds == 8));
      end
    end
  endtask

  initial begin
    gif.gradeIt      = 1'b0;
    gif.gamePlaying  = 1'b1;
    gif.masterLoaded = 1'b1;
    set_master(pack4(1,2,3,4));
    set_guess(pack4(1,1,1,1));
    test_reset();
    test_exact_win();
    test_patterns();
    test_invalid();
    test_rounds();
    test_reset_mid();
    test_abort();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
